flag_rf_core: RTL and testbench
===============================

Name: flag_rf_core

Overview:
- Condition-flag register file for the CPU datapath.
- Captures the ALU status flags Z (zero), V (overflow) and N (negative) on each rising clock edge.
- Evaluates a 4-bit branch/predication condition code against the stored flags.
- Drives a single "condition true" bit to the branch and predication logic.

Parameters:
- RESET_FLAGS, 3'b000, value loaded into stored {Z,V,N} on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- cond  input  4  condition code selector; codes are defined in the shared package.
- z  input  1  ALU zero flag to capture.
- v  input  1  ALU signed-overflow flag to capture.
- n  input  1  ALU negative flag to capture.
- out  output  1  1 when the selected condition holds for the stored flags.

Behaviour:
- One clock domain; reset is synchronous and active-low.
- Reset: on a rising clk edge with rst_n=0, stored {Z,V,N} take RESET_FLAGS. Reset has priority over flag capture.
- Flag capture: on a rising clk edge with rst_n=1, stored Z, V and N take the z, v and n inputs. All three update together every cycle.
- Output timing: out is a combinational function of cond and the stored flags only, never the live flag inputs.
  - A flag change is visible on out after the next rising edge.
  - A cond change is visible on out immediately, within the same cycle.
- Reset value of out: with RESET_FLAGS=000 (Z=0, V=0, N=0):
  - out = 1 for GREATER, GREATER_EQUAL, NOT_EQUAL, POSITIVE, NO_OVERFLOW and ALWAYS.
  - out = 0 for all other codes.
- Condition codes (value: mnemonic = function):
  - 0: EQUAL = Z
  - 1: NOT_EQUAL = !Z
  - 2: LESS = N ^ V
  - 3: GREATER = !Z & !(N ^ V)
  - 4: LESS_EQUAL = Z | (N ^ V)
  - 5: GREATER_EQUAL = !(N ^ V)
  - 6: NEGATIVE = N
  - 7: POSITIVE = !N
  - 8: OVERFLOW = V
  - 9: NO_OVERFLOW = !V
  - 10: ALWAYS = 1
  - 11–15: reserved, out = 0
- Boundary conditions:
  - Any X or Z on cond drives out to 0 (default branch). Reserved codes never assert out.
  - Reset asserted mid-operation takes effect at the next edge, regardless of the flag inputs.
  - There is no carry flag. Unsigned compares are out of scope.

Optional Feature:
- Macro FLAG_RF_WE_EN.
- When defined:
  - An extra input port we (1 bit) is added after rst_n.
  - Stored flags update only on edges where rst_n=1 and we=1; they hold when we=0.
  - Reset still loads RESET_FLAGS regardless of we.
- When undefined:
  - No we port exists.
  - Flags update on every non-reset edge, exactly as in Behaviour.

Decomposition:
- Shared package flag_pkg holds:
  - the 4-bit condition-code constants EQUAL … ALWAYS (values as listed in Behaviour);
  - the condition-code width constant (4);
  - a typedef for the packed {Z,V,N} flag vector.
- One sub-module, flag_cond_eval: purely combinational, maps cond plus stored flags to out.
- Top level holds only the flag register and any write-enable gating.

Test Plan:
- Reset: rst_n=0 for one edge with z=1, v=1, n=1, then rst_n=1 without a further edge; cond=EQUAL -> out=0; cond=GREATER -> out=1.
- EQUAL: z=1, v=0, n=0, edge -> out=1; then z=0, edge -> out=0. A z change without an edge leaves out unchanged.
- LESS:
  - n=1, v=0, z=0, edge -> out=1;
  - n=0, v=0, edge -> out=0;
  - n=1, v=1, edge -> out=0.
- GREATER:
  - z=0, v=0, n=0, edge -> out=1;
  - n=1, edge -> out=0;
  - n=0, v=1, edge -> out=0;
  - z=1, v=0, n=0, edge -> out=0.
- Sweep: with stored flags fixed at Z=0, V=1, N=0, step cond 0..15 with no edge -> out = 0,1,1,0,1,0,0,1,1,0,1,0,0,0,0,0.
- FLAG_RF_WE_EN:
  - we=1, z=1, edge -> EQUAL out=1;
  - we=0, z=0, edge -> out stays 1;
  - rst_n=0 with we=0, edge -> out=0.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared condition-code encodings and flag vector type for the flag register file.
package flag_pkg;

  localparam int unsigned COND_W = 4;

  typedef logic [COND_W-1:0] cond_t;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  localparam cond_t EQUAL         = COND_W'(0);
  localparam cond_t NOT_EQUAL     = COND_W'(1);
  localparam cond_t LESS          = COND_W'(2);
  localparam cond_t GREATER       = COND_W'(3);
  localparam cond_t LESS_EQUAL    = COND_W'(4);
  localparam cond_t GREATER_EQUAL = COND_W'(5);
  localparam cond_t NEGATIVE      = COND_W'(6);
  localparam cond_t POSITIVE      = COND_W'(7);
  localparam cond_t OVERFLOW      = COND_W'(8);
  localparam cond_t NO_OVERFLOW   = COND_W'(9);
  localparam cond_t ALWAYS        = COND_W'(10);

endpackage

// File: rtl/flag_rf_core_if.sv
// Flag capture / condition query bus between the ALU side and the flag register file.
interface flag_rf_core_if;
  import flag_pkg::*;

  cond_t cond;
  logic  z;
  logic  v;
  logic  n;
  logic  out;

  modport master (output cond, output z, output v, output n, input out);
  modport slave  (input cond, input z, input v, input n, output out);
endinterface

// File: rtl/flag_cond_eval.sv
// Combinational evaluation of a condition code against the stored {Z,V,N} flags.
module flag_cond_eval
  import flag_pkg::*;
(
  input  cond_t  cond,
  input  flags_t flags,
  output logic   out
);

  logic lt;

  // Reserved or unknown codes fall into the default and never assert out.
  always_comb begin
    out = 1'b0;
    lt  = flags.n ^ flags.v;
    case (cond)
      EQUAL:         out = flags.z;
      NOT_EQUAL:     out = ~flags.z;
      LESS:          out = lt;
      GREATER:       out = ~flags.z & ~lt;
      LESS_EQUAL:    out = flags.z | lt;
      GREATER_EQUAL: out = ~lt;
      NEGATIVE:      out = flags.n;
      POSITIVE:      out = ~flags.n;
      OVERFLOW:      out = flags.v;
      NO_OVERFLOW:   out = ~flags.v;
      ALWAYS:        out = 1'b1;
      default:       out = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_rf_core.sv
// Condition-flag register file: captures ALU {Z,V,N} and evaluates branch conditions.
// Optional write enable on the flag register via macro FLAG_RF_WE_EN.
module flag_rf_core
  import flag_pkg::*;
#(
  parameter logic [2:0] RESET_FLAGS = 3'b000
)(
  input  logic           clk,
  input  logic           rst_n,
`ifdef FLAG_RF_WE_EN
  input  logic           we,
`endif
  flag_rf_core_if.slave  bus
);

  flags_t flags_q;
  logic   cap_en;

`ifdef FLAG_RF_WE_EN
  assign cap_en = we;
`else
  assign cap_en = 1'b1;
`endif

  // Synchronous reset wins over capture; write enable only gates capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= flags_t'(RESET_FLAGS);
    end else if (cap_en) begin
      flags_q <= '{z: bus.z, v: bus.v, n: bus.n};
    end
  end

  flag_cond_eval u_eval (
    .cond  (bus.cond),
    .flags (flags_q),
    .out   (bus.out)
  );

endmodule

// File: tb/tb_flag_rf_core.sv
// Self-checking bench for flag_rf_core: drives flags and conditions, compares out directly.
module tb_flag_rf_core;
  import flag_pkg::*;

  logic clk;
  logic rst_n;
`ifdef FLAG_RF_WE_EN
  logic we;
`endif

  flag_rf_core_if bus ();

  flag_rf_core #(.RESET_FLAGS(3'b000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef FLAG_RF_WE_EN
    .we    (we),
`endif
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input bit e);
    #1;
    tests++;
    if (bus.out !== e) begin
      fails++;
      $display("FAIL %s: out=%b expected=%b", nm, bus.out, e);
    end
  endtask

  task automatic set_flags(input logic zz, input logic vv, input logic nn);
    bus.z = zz;
    bus.v = vv;
    bus.n = nn;
  endtask

  // Expected outs for stored Z=0,V=1,N=0 across all 16 codes.
  localparam logic [15:0] SWEEP_EXP = 16'b0000_0101_1001_0110;

  initial begin
    logic [15:0] sweep;
    sweep = SWEEP_EXP;
    rst_n = 1'b1;
`ifdef FLAG_RF_WE_EN
    we = 1'b1;
`endif
    bus.cond = EQUAL;
    set_flags(1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset with all flag inputs high; check before the next edge.
    rst_n = 1'b0;
    set_flags(1'b1, 1'b1, 1'b1);
    step();
    rst_n = 1'b1;
    bus.cond = EQUAL;
    chk("reset_equal", 1'b0);
    bus.cond = GREATER;
    chk("reset_greater", 1'b1);

    // EQUAL, including a z change with no edge.
    bus.cond = EQUAL;
    set_flags(1'b1, 1'b0, 1'b0);
    step();
    chk("eq_z1", 1'b1);
    bus.z = 1'b0;
    chk("eq_no_edge", 1'b1);
    step();
    chk("eq_z0", 1'b0);

    // LESS
    bus.cond = LESS;
    set_flags(1'b0, 1'b0, 1'b1);
    step(); chk("lt_n1v0", 1'b1);
    set_flags(1'b0, 1'b0, 1'b0);
    step(); chk("lt_n0v0", 1'b0);
    set_flags(1'b0, 1'b1, 1'b1);
    step(); chk("lt_n1v1", 1'b0);

    // GREATER
    bus.cond = GREATER;
    set_flags(1'b0, 1'b0, 1'b0);
    step(); chk("gt_000", 1'b1);
    set_flags(1'b0, 1'b0, 1'b1);
    step(); chk("gt_n1", 1'b0);
    set_flags(1'b0, 1'b1, 1'b0);
    step(); chk("gt_v1", 1'b0);
    set_flags(1'b1, 1'b0, 1'b0);
    step(); chk("gt_z1", 1'b0);

    // Sweep all codes with stored Z=0,V=1,N=0 held on the inputs.
    set_flags(1'b0, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 16; i++) begin
      bus.cond = cond_t'(i);
      #1;
      tests++;
      if (bus.out !== sweep[i]) begin
        fails++;
        $display("FAIL sweep_%0d: out=%b expected=%b", i, bus.out, sweep[i]);
      end
    end

    // Unknown cond never asserts out.
    bus.cond = 4'bxxxx;
    chk("cond_x", 1'b0);

    // Mid-operation reset overrides flag inputs.
    bus.cond = EQUAL;
    set_flags(1'b1, 1'b1, 1'b1);
    step(); chk("pre_reset_eq", 1'b1);
    rst_n = 1'b0;
    step(); chk("mid_reset_eq", 1'b0);
    bus.cond = NO_OVERFLOW;
    chk("mid_reset_nov", 1'b1);
    rst_n = 1'b1;

`ifdef FLAG_RF_WE_EN
    bus.cond = EQUAL;
    we = 1'b1;
    set_flags(1'b1, 1'b0, 1'b0);
    step(); chk("we1_capture", 1'b1);
    we = 1'b0;
    bus.z = 1'b0;
    step(); chk("we0_hold", 1'b1);
    rst_n = 1'b0;
    step(); chk("we0_reset", 1'b0);
    rst_n = 1'b1;
`endif

    if (fails != 0 || tests < 12) begin
      $display("FAIL summary: %0d of %0d checks failed", fails, tests);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: run did not complete, tests=%0d expected all checks done", tests);
    $fatal(1, "timeout");
  end

endmodule
